// File: rtl/antilog_iter.sv
// Sequential fixed-point antilog y = 2^x: one shared 32x32 multiply per fractional bit,
// then a barrel-shift normalise. Define ANTILOG_ROUND_EN for round-half-up instead of truncation.
module antilog_iter #(
  parameter int INT_W    = 6,
  parameter int FRAC_W   = 16,
  parameter int OUT_W    = 64,
  parameter int OUT_FRAC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INT_W+FRAC_W-1:0] x,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        y,
  output logic                    ovf
);
  localparam int          XW   = INT_W + FRAC_W;
  localparam int          CW   = $clog2(FRAC_W + 2);
  localparam int          WW   = OUT_W + 32;
  localparam int          SH   = 30 - OUT_FRAC;
  localparam int          HB   = (SH > 0) ? SH - 1 : 0;
  localparam logic [31:0] ONE  = 32'h4000_0000;
  localparam logic [31:0] KSAT = 32'(OUT_W - OUT_FRAC);

  typedef enum logic [1:0] {IDLE, ITER, NORM, DONE} state_e;

  state_e            state_q, state_d;
  logic [INT_W-1:0]  k_q, k_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [31:0]       m_q, m_d;
  logic [CW-1:0]     i_q, i_d;
  logic [OUT_W-1:0]  y_q, y_d;
  logic              ovf_q, ovf_d;

  // C[i] = round(2^(2^-i) * 2^30)
  function automatic logic [31:0] rom_c(input logic [CW-1:0] idx);
    logic [31:0] c;
    case (int'(idx))
      1:       c = 32'd1518500250;
      2:       c = 32'd1276901417;
      3:       c = 32'd1170923762;
      4:       c = 32'd1121280436;
      5:       c = 32'd1097253708;
      6:       c = 32'd1085434106;
      7:       c = 32'd1079572136;
      8:       c = 32'd1076653033;
      9:       c = 32'd1075196443;
      10:      c = 32'd1074468888;
      11:      c = 32'd1074105294;
      12:      c = 32'd1073923544;
      13:      c = 32'd1073832680;
      14:      c = 32'd1073787251;
      15:      c = 32'd1073764537;
      16:      c = 32'd1073753181;
      default: c = ONE;
    endcase
    return c;
  endfunction

  logic [63:0] prod, prod_r;
  logic [31:0] m_mul;
  assign prod = 64'(m_q) * 64'(rom_c(i_q));
`ifdef ANTILOG_ROUND_EN
  assign prod_r = prod + 64'h2000_0000;
`else
  assign prod_r = prod;
`endif
  assign m_mul = prod_r[61:30];

  logic [31:0]   k_ext;
  logic          sat;
  logic [WW-1:0] wide, wide_r, shr;
  assign k_ext = {{(32-INT_W){1'b0}}, k_q};
  assign sat   = (k_ext >= KSAT);
  assign wide  = WW'(m_q) << k_q;
`ifdef ANTILOG_ROUND_EN
  // Half-LSB only matters while the shift is still a net right shift.
  assign wide_r = (k_ext < 32'(SH)) ? wide + (WW'(1) << HB) : wide;
`else
  assign wide_r = wide;
`endif
  assign shr = wide_r >> SH;

  logic unused_bits;
  assign unused_bits = ^{prod_r[63:62], prod_r[29:0], shr[WW-1:OUT_W]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      frac_q  <= '0;
      m_q     <= ONE;
      i_q     <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      frac_q  <= frac_d;
      m_q     <= m_d;
      i_q     <= i_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    frac_d  = frac_q;
    m_d     = m_q;
    i_d     = i_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          k_d     = x[XW-1:FRAC_W];
          frac_d  = x[FRAC_W-1:0];
          m_d     = ONE;
          i_d     = CW'(1);
          state_d = ITER;
        end
      end
      ITER: begin
        // frac_q shifts left so its MSB is always x[FRAC_W-i]
        if (i_q > CW'(FRAC_W)) begin
          state_d = NORM;
        end else begin
          if (frac_q[FRAC_W-1]) m_d = m_mul;
          frac_d = frac_q << 1;
          i_d    = i_q + CW'(1);
        end
      end
      NORM: begin
        if (sat) begin
          y_d   = '1;
          ovf_d = 1'b1;
        end else begin
          y_d   = shr[OUT_W-1:0];
          ovf_d = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_antilog_iter.sv
// Bench for antilog_iter: directed spec points plus random x against a reference
// model; a negedge monitor pops the expected-result queue on every output handshake.
module tb_antilog_iter;
  localparam int INT_W = 6, FRAC_W = 16, OUT_W = 64, OUT_FRAC = 16;
  localparam int XW = INT_W + FRAC_W;

  typedef longint unsigned u64_t;
  typedef struct packed {
    logic [XW-1:0] x;
    logic [63:0]   y;
    logic          ovf;
  } exp_t;

  logic             clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [XW-1:0]    x = '0;
  logic             in_ready, out_valid, ovf;
  logic [OUT_W-1:0] y;

  exp_t exp_q[$];
  int   tests = 0, fails = 0;
  bit   rnd_rdy = 1'b0;
  u64_t crom[17];

  antilog_iter #(.INT_W(INT_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [XW-1:0] xv, input logic [63:0] yv, input logic ov);
    exp_t e;
    e.x = xv; e.y = yv; e.ovf = ov;
    return e;
  endfunction

  // Reference: product over set fraction bits of 2^(2^-i), then scale by 2^k
  function automatic exp_t model(input logic [XW-1:0] xv);
    exp_t e;
    u64_t m, p;
    int   k;
    e.x = xv;
    m = u64_t'(1) << 30;
    for (int i = 1; i <= FRAC_W; i++) begin
      if (xv[FRAC_W-i]) begin
        p = m * crom[i];
`ifdef ANTILOG_ROUND_EN
        p = p + (u64_t'(1) << 29);
`endif
        m = p >> 30;
      end
    end
    k = int'(xv[XW-1:FRAC_W]);
    if (k >= OUT_W - OUT_FRAC) begin
      e.y = '1; e.ovf = 1'b1;
    end else begin
      e.ovf = 1'b0;
      if (k >= 30 - OUT_FRAC) e.y = m << (k - (30 - OUT_FRAC));
      else begin
`ifdef ANTILOG_ROUND_EN
        m = m + (u64_t'(1) << (30 - OUT_FRAC - 1 - k));
`endif
        e.y = m >> (30 - OUT_FRAC - k);
      end
    end
    return e;
  endfunction

  task automatic send(input exp_t e);
    int n = 0;
    while (!in_ready && n < 300) begin
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready=%0b required 1 for x=0x%0h", in_ready, e.x);
    end else begin
      in_valid = 1'b1;
      x = e.x;
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output: y=0x%0h ovf=%0b with no pending request", y, ovf);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("y(x=0x%0h)", e.x), y, e.y);
        check($sformatf("ovf(x=0x%0h)", e.x), 64'(ovf), 64'(e.ovf));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XW-1:0] dx[6];
    logic [63:0]   dy[6];
    logic          dov[6];
    logic [XW-1:0] xv;
    int            n;
    real           r;

    for (int i = 1; i <= 16; i++) begin
      r = (2.0 ** (1.0 / (2.0 ** i))) * 1073741824.0;
      crom[i] = u64_t'($floor(r + 0.5));
    end

    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", {61'd0, in_ready, out_valid, ovf}, 64'b100);
    check("reset_y", y, 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // x=0, with out_ready held high in advance
    send(mk('0, 64'h10000, 1'b0));
    wait_valid(n);
    check("latency_cycles", 64'(n), 64'd18);
    @(posedge clk); #1;
    check("retire_first_done", {62'd0, in_ready, out_valid}, 64'b10);

    dx[0] = 22'h010000; dy[0] = 64'h20000;          dov[0] = 1'b0;
    dx[1] = 22'h0A0000; dy[1] = 64'h4000000;        dov[1] = 1'b0;
`ifdef ANTILOG_ROUND_EN
    dx[2] = 22'h008000; dy[2] = 64'h16A0A;          dov[2] = 1'b0;
`else
    dx[2] = 22'h008000; dy[2] = 64'h16A09;          dov[2] = 1'b0;
`endif
    dx[3] = 22'h300000; dy[3] = '1;                 dov[3] = 1'b1;
    dx[4] = 22'h3FFFFF; dy[4] = '1;                 dov[4] = 1'b1;
    dx[5] = 22'h2F0000; dy[5] = 64'h8000000000000000; dov[5] = 1'b0;
    for (int i = 0; i < 6; i++) send(mk(dx[i], dy[i], dov[i]));

    // Backpressure in DONE with a competing in_valid
    send(mk(22'h010000, 64'h20000, 1'b0));
    out_ready = 1'b0;
    wait_valid(n);
    in_valid = 1'b1;
    x = '0;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_y", y, 64'h20000);
      check("bp_flags", {61'd0, out_valid, in_ready, ovf}, 64'b100);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {62'd0, in_ready, out_valid}, 64'b10);
    n = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("bp_ignored_input", 64'(n), 64'd0);

    // Reset while the 7th iteration is being applied
    send(model(22'h1ABCDE));
    repeat (6) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    check("midreset_flags", {62'd0, out_valid, in_ready}, 64'b01);
    check("midreset_y", y, 64'd0);
    send(mk(22'h010000, 64'h20000, 1'b0));

    rnd_rdy = 1'b1;
    repeat (40) begin
      xv = XW'($urandom);
      send(model(xv));
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;

    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
